// File: rtl/chrono_pkg.sv
// Shared types and constants for the lap chronometer.
package chrono_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StLap,
        StStop
    } state_e;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

    // Terminal value of the prescaler: it counts 0..terminal, one tick per wrap.
    function automatic int unsigned presc_term(input int unsigned clk_hz,
                                               input int unsigned tick_hz);
        return (clk_hz / tick_hz) - 1;
    endfunction

endpackage

// File: rtl/lap_chronometer_if.sv
// Board-side signals of the chronometer: raw buttons, pair select and LED bank.
interface lap_chronometer_if #(
    parameter int unsigned SELW = 1
);
    logic            btn_start_stop;
    logic            btn_lap;
    logic            btn_clear;
    logic [SELW-1:0] sel;
    logic [7:0]      led;
    logic            running;
    logic            overflow;

    modport master (
        output btn_start_stop, btn_lap, btn_clear, sel,
        input  led, running, overflow
    );

    modport slave (
        input  btn_start_stop, btn_lap, btn_clear, sel,
        output led, running, overflow
    );
endinterface

// File: rtl/bcd_digit_cell.sv
// One BCD decade of the count chain with clear, enable and saturation hold.
module bcd_digit_cell
    import chrono_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic en_i,
    input  logic hold_i,
    output bcd_t digit_o,
    output logic carry_o
);
    bcd_t digit_q, digit_d;

    // Next digit: clear wins, otherwise step 0..9 when enabled and not held.
    always_comb begin
        digit_d = digit_q;
        if (clear_i) begin
            digit_d = '0;
        end else if (en_i && !hold_i) begin
            digit_d = (digit_q == BCD_MAX) ? bcd_t'(0) : digit_q + bcd_t'(1);
        end
    end

    // Digit register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) digit_q <= '0;
        else       digit_q <= digit_d;
    end

    assign digit_o = digit_q;
    // Carry ignores hold so the top carry still flags overflow when saturated.
    assign carry_o = en_i && (digit_q == BCD_MAX);
endmodule

// File: rtl/lap_chronometer.sv
// Single-clock stopwatch: button sync/edge detect, prescaler, BCD chain, lap FSM, LED window.
module lap_chronometer
    import chrono_pkg::*;
#(
    parameter int unsigned N_DIGITS = 4,
    parameter int unsigned CLK_HZ   = 50_000_000,
    parameter int unsigned TICK_HZ  = 100,
    parameter int unsigned WRAP     = 1,
    parameter int unsigned SELW     = (N_DIGITS / 2 > 1) ? $clog2(N_DIGITS / 2) : 1
) (
    input  logic clk_i,
    input  logic rst_i,
    lap_chronometer_if.slave bus_io
);
    localparam int unsigned Div    = CLK_HZ / TICK_HZ;
    localparam int unsigned PW     = $clog2(Div);
    localparam logic [PW-1:0] PTerm = PW'(presc_term(CLK_HZ, TICK_HZ));
    localparam int unsigned NPairs = N_DIGITS / 2;

    logic [2:0] sync1_q, sync2_q, prev_q, btn_evt;
    logic       ev_ss, ev_lap, ev_clr;

    state_e                    state_q, state_d;
    logic [PW-1:0]             presc_q, presc_d;
    logic                      ovf_q, ovf_d;
    logic [N_DIGITS-1:0][3:0]  live, snap_q, snap_d, src;
    logic [7:0]                led_q, led_d;
    logic [N_DIGITS-1:0]       en, carry;
    logic                      running, tick, all_nines, hold, ovf_evt, sat_stop, snap_take;

    // Two-flop synchronisers plus previous-value flop for rising-edge detect.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= {bus_io.btn_clear, bus_io.btn_lap, bus_io.btn_start_stop};
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign btn_evt = sync2_q & ~prev_q;
    assign ev_ss   = btn_evt[0];
    assign ev_lap  = btn_evt[1];
    assign ev_clr  = btn_evt[2];

    assign running = (state_q == StRun) || (state_q == StLap);
    assign tick    = running && (presc_q == PTerm);

    // Prescaler advances only while running; stop holds it, clear zeroes it.
    always_comb begin
        presc_d = presc_q;
        if (ev_clr)       presc_d = '0;
        else if (tick)    presc_d = '0;
        else if (running) presc_d = presc_q + PW'(1);
    end

    for (genvar k = 0; k < N_DIGITS; k++) begin : g_digit
        if (k == 0) begin : g_first
            assign en[k] = tick;
        end else begin : g_rest
            assign en[k] = carry[k-1];
        end
        bcd_digit_cell u_cell (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .clear_i (ev_clr),
            .en_i    (en[k]),
            .hold_i  (hold),
            .digit_o (live[k]),
            .carry_o (carry[k])
        );
    end

    // All-nines detect drives saturation hold when wrapping is disabled.
    always_comb begin
        all_nines = 1'b1;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (live[k] != BCD_MAX) all_nines = 1'b0;
        end
    end

    assign hold     = (WRAP == 0) && all_nines;
    assign ovf_evt  = carry[N_DIGITS-1];
    assign sat_stop = (WRAP == 0) && ovf_evt;

    // FSM next state with clear > start/stop > lap; saturation forces STOP.
    always_comb begin
        state_d   = state_q;
        snap_take = 1'b0;
        if (ev_clr) begin
            state_d = StIdle;
        end else begin
            if (ev_ss) begin
                unique case (state_q)
                    StIdle, StStop: state_d = StRun;
                    StRun, StLap:   state_d = StStop;
                    default:        state_d = StIdle;
                endcase
            end else if (ev_lap && running) begin
                state_d   = StLap;
                snap_take = 1'b1;
            end
            if (sat_stop) state_d = StStop;
        end
    end

    // Sticky overflow, snapshot capture (pre-increment value) and LED pair select.
    always_comb begin
        ovf_d  = ev_clr ? 1'b0 : (ovf_q || ovf_evt);
        snap_d = snap_take ? live : snap_q;
        src    = (state_q == StLap) ? snap_q : live;
        led_d  = '0;
        for (int p = 0; p < NPairs; p++) begin
            if (int'(bus_io.sel) == p) led_d = {src[2*p+1], src[2*p]};
        end
    end

    // Control and display registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            presc_q <= '0;
            ovf_q   <= 1'b0;
            snap_q  <= '0;
            led_q   <= '0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            ovf_q   <= ovf_d;
            snap_q  <= snap_d;
            led_q   <= led_d;
        end
    end

    assign bus_io.led      = led_q;
    assign bus_io.running  = running;
    assign bus_io.overflow = ovf_q;
endmodule

// File: tb/tb_lap_chronometer.sv
// Bench for lap_chronometer: directed scenarios plus random presses against a tick-count model.
module tb_lap_chronometer;

    localparam int MI = 0;
    localparam int MR = 1;
    localparam int ML = 2;
    localparam int MS = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       b_ss = 1'b0, b_lap = 1'b0, b_clr = 1'b0;
    logic [0:0] sel = 1'b0;
    int         dsel = 0;

    int checks = 0;
    int errors = 0;

    // Reference model: count expressed as a plain number of ticks.
    int         m_st, m_presc, m_ticks, m_snap, m_div, m_nd, m_max;
    bit         m_wrap, m_ovf;
    logic [7:0] m_led;

    logic [7:0] o_led;
    logic       o_run, o_ovf;

    always #5 clk = ~clk;

    lap_chronometer_if #(.SELW(1)) if4 ();
    lap_chronometer_if #(.SELW(1)) if2w ();
    lap_chronometer_if #(.SELW(1)) if2s ();

    assign if4.btn_start_stop  = (dsel == 0) && b_ss;
    assign if4.btn_lap         = (dsel == 0) && b_lap;
    assign if4.btn_clear       = (dsel == 0) && b_clr;
    assign if4.sel             = sel;
    assign if2w.btn_start_stop = (dsel == 1) && b_ss;
    assign if2w.btn_lap        = (dsel == 1) && b_lap;
    assign if2w.btn_clear      = (dsel == 1) && b_clr;
    assign if2w.sel            = sel;
    assign if2s.btn_start_stop = (dsel == 2) && b_ss;
    assign if2s.btn_lap        = (dsel == 2) && b_lap;
    assign if2s.btn_clear      = (dsel == 2) && b_clr;
    assign if2s.sel            = sel;

    assign o_led = (dsel == 0) ? if4.led : (dsel == 1) ? if2w.led : if2s.led;
    assign o_run = (dsel == 0) ? if4.running : (dsel == 1) ? if2w.running : if2s.running;
    assign o_ovf = (dsel == 0) ? if4.overflow : (dsel == 1) ? if2w.overflow : if2s.overflow;

    lap_chronometer #(.N_DIGITS(4), .CLK_HZ(1000), .TICK_HZ(100), .WRAP(1)) dut4 (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus_io (if4)
    );
    lap_chronometer #(.N_DIGITS(2), .CLK_HZ(1000), .TICK_HZ(100), .WRAP(1)) dut2w (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus_io (if2w)
    );
    lap_chronometer #(.N_DIGITS(2), .CLK_HZ(1000), .TICK_HZ(100), .WRAP(0)) dut2s (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus_io (if2s)
    );

    function automatic logic [7:0] pair_of(input int val, input int s, input int nd);
        int p;
        int scale;
        if (s >= nd / 2) return 8'h00;
        scale = 1;
        for (int i = 0; i < s; i++) scale *= 100;
        p = (val / scale) % 100;
        return 8'((p / 10) * 16 + (p % 10));
    endfunction

    task automatic model_reset();
        m_st = MI; m_presc = 0; m_ticks = 0; m_snap = 0; m_ovf = 1'b0; m_led = 8'h00;
    endtask

    task automatic select_dut(input int k, input int nd, input bit wrap);
        dsel = k; m_nd = nd; m_wrap = wrap; m_div = 10;
        m_max = (nd == 2) ? 99 : 9999;
    endtask

    // One clock edge of the model; the events are those resolved at this edge.
    task automatic step(input bit ss, input bit lap, input bit clr);
        int old_st;
        int pre;
        bit sat;
        @(posedge clk);
        old_st = m_st;
        m_led  = pair_of((old_st == ML) ? m_snap : m_ticks, int'(sel), m_nd);
        pre    = m_ticks;
        sat    = 1'b0;
        if (old_st == MR || old_st == ML) begin
            m_presc++;
            if (m_presc == m_div) begin
                m_presc = 0;
                if (m_ticks == m_max) begin
                    m_ovf = 1'b1;
                    if (m_wrap) m_ticks = 0;
                    else        sat = 1'b1;
                end else begin
                    m_ticks++;
                end
            end
        end
        if (clr) begin
            m_st = MI; m_presc = 0; m_ticks = 0; m_ovf = 1'b0;
        end else begin
            if (ss) m_st = (old_st == MR || old_st == ML) ? MS : MR;
            else if (lap && (old_st == MR || old_st == ML)) begin
                m_st = ML; m_snap = pre;
            end
            if (sat) m_st = MS;
        end
        #1;
    endtask

    // Button press: takes effect on the third edge, then released for two edges.
    task automatic press(input bit ss, input bit lap, input bit clr);
        b_ss = ss; b_lap = lap; b_clr = clr;
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(ss, lap, clr);
        b_ss = 1'b0; b_lap = 1'b0; b_clr = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            dsel = k;
            #0;
            checks++; if (o_led !== 8'h00) begin errors++; $display("FAIL reset_led dut%0d got=%h exp=00", k, o_led); end
            checks++; if (o_run !== 1'b0) begin errors++; $display("FAIL reset_running dut%0d got=%b exp=0", k, o_run); end
            checks++; if (o_ovf !== 1'b0) begin errors++; $display("FAIL reset_overflow dut%0d got=%b exp=0", k, o_ovf); end
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_count();
        select_dut(0, 4, 1'b1);
        sel = 1'b0;
        press(1'b1, 1'b0, 1'b0);
        repeat (12341) step(1'b0, 1'b0, 1'b0);
        checks++; if (o_led !== 8'h34) begin errors++; $display("FAIL count_sel0 got=%h exp=34", o_led); end
        checks++; if (o_run !== 1'b1) begin errors++; $display("FAIL count_running got=%b exp=1", o_run); end
        sel = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        checks++; if (o_led !== 8'h12) begin errors++; $display("FAIL count_sel1 got=%h exp=12", o_led); end
    endtask

    task automatic test_lap();
        select_dut(0, 4, 1'b1);
        press(1'b0, 1'b0, 1'b1);
        sel = 1'b0;
        press(1'b1, 1'b0, 1'b0);
        repeat (12338) step(1'b0, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        repeat (1000) step(1'b0, 1'b0, 1'b0);
        checks++; if (o_led !== 8'h34) begin errors++; $display("FAIL lap_frozen got=%h exp=34", o_led); end
        checks++; if (o_run !== 1'b1) begin errors++; $display("FAIL lap_running got=%b exp=1", o_run); end
        press(1'b0, 1'b1, 1'b0);
        checks++; if (o_led !== 8'h34) begin errors++; $display("FAIL split_sel0 got=%h exp=34", o_led); end
        sel = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        checks++; if (o_led !== 8'h13) begin errors++; $display("FAIL split_sel1 got=%h exp=13", o_led); end
        sel = 1'b0;
        press(1'b1, 1'b0, 1'b0);
        checks++; if (o_led !== 8'h35) begin errors++; $display("FAIL lap_stop_live got=%h exp=35", o_led); end
        checks++; if (o_run !== 1'b0) begin errors++; $display("FAIL lap_stop_running got=%b exp=0", o_run); end
    endtask

    task automatic test_overflow();
        select_dut(1, 2, 1'b1);
        sel = 1'b0;
        press(1'b0, 1'b0, 1'b1);
        press(1'b1, 1'b0, 1'b0);
        repeat (999) step(1'b0, 1'b0, 1'b0);
        checks++; if (o_led !== 8'h00) begin errors++; $display("FAIL wrap_led got=%h exp=00", o_led); end
        checks++; if (o_ovf !== 1'b1) begin errors++; $display("FAIL wrap_overflow got=%b exp=1", o_ovf); end
        press(1'b0, 1'b0, 1'b1);
        checks++; if (o_ovf !== 1'b0) begin errors++; $display("FAIL wrap_clear_ovf got=%b exp=0", o_ovf); end
        checks++; if (o_run !== 1'b0) begin errors++; $display("FAIL wrap_clear_running got=%b exp=0", o_run); end

        select_dut(2, 2, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        press(1'b1, 1'b0, 1'b0);
        repeat (999) step(1'b0, 1'b0, 1'b0);
        checks++; if (o_led !== 8'h99) begin errors++; $display("FAIL sat_led got=%h exp=99", o_led); end
        checks++; if (o_run !== 1'b0) begin errors++; $display("FAIL sat_running got=%b exp=0", o_run); end
        checks++; if (o_ovf !== 1'b1) begin errors++; $display("FAIL sat_overflow got=%b exp=1", o_ovf); end
        repeat (30) step(1'b0, 1'b0, 1'b0);
        checks++; if (o_led !== 8'h99) begin errors++; $display("FAIL sat_hold got=%h exp=99", o_led); end
        sel = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        checks++; if (o_led !== 8'h00) begin errors++; $display("FAIL sel_out_of_range got=%h exp=00", o_led); end
        sel = 1'b0;
    endtask

    task automatic test_simultaneous();
        select_dut(0, 4, 1'b1);
        press(1'b0, 1'b0, 1'b1);
        press(1'b1, 1'b0, 1'b0);
        repeat (200) step(1'b0, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b1);
        checks++; if (o_led !== 8'h00) begin errors++; $display("FAIL clr_ss_led got=%h exp=00", o_led); end
        checks++; if (o_run !== 1'b0) begin errors++; $display("FAIL clr_ss_running got=%b exp=0", o_run); end
        press(1'b1, 1'b0, 1'b0);
        repeat (300) step(1'b0, 1'b0, 1'b0);
        press(1'b1, 1'b1, 1'b0);
        checks++; if (o_run !== 1'b0) begin errors++; $display("FAIL ss_lap_running got=%b exp=0", o_run); end
        checks++; if (o_led !== m_led) begin errors++; $display("FAIL ss_lap_live got=%h exp=%h", o_led, m_led); end
        press(1'b0, 1'b1, 1'b0);
        checks++; if (o_run !== 1'b0) begin errors++; $display("FAIL stop_lap_ignored got=%b exp=0", o_run); end
        checks++; if (o_led !== m_led) begin errors++; $display("FAIL stop_lap_led got=%h exp=%h", o_led, m_led); end
    endtask

    task automatic test_prescaler();
        select_dut(0, 4, 1'b1);
        sel = 1'b0;
        press(1'b0, 1'b0, 1'b1);
        press(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        checks++; if (o_led !== 8'h00) begin errors++; $display("FAIL resume_early got=%h exp=00", o_led); end
        step(1'b0, 1'b0, 1'b0);
        checks++; if (o_led !== 8'h01) begin errors++; $display("FAIL resume_tick got=%h exp=01", o_led); end

        repeat (50) step(1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        checks++; if (o_led !== 8'h00) begin errors++; $display("FAIL midreset_led got=%h exp=00", o_led); end
        checks++; if (o_run !== 1'b0) begin errors++; $display("FAIL midreset_running got=%b exp=0", o_run); end
        checks++; if (o_ovf !== 1'b0) begin errors++; $display("FAIL midreset_overflow got=%b exp=0", o_ovf); end
        #1;
        rst = 1'b0;
        model_reset();
        repeat (40) step(1'b0, 1'b0, 1'b0);
        checks++; if (o_led !== 8'h00) begin errors++; $display("FAIL postreset_led got=%h exp=00", o_led); end
        checks++; if (o_run !== 1'b0) begin errors++; $display("FAIL postreset_running got=%b exp=0", o_run); end
    endtask

    task automatic test_random();
        int r;
        int n;
        select_dut(0, 4, 1'b1);
        press(1'b0, 1'b0, 1'b1);
        for (int it = 0; it < 80; it++) begin
            r = int'($urandom_range(0, 9));
            if (r < 6) begin
                n = int'($urandom_range(1, 25));
                for (int j = 0; j < n; j++) begin
                    step(1'b0, 1'b0, 1'b0);
                    checks++; if (o_led !== m_led) begin errors++; $display("FAIL rand_led it%0d got=%h exp=%h", it, o_led, m_led); end
                    checks++; if (o_run !== (m_st == MR || m_st == ML)) begin errors++; $display("FAIL rand_running it%0d got=%b", it, o_run); end
                    checks++; if (o_ovf !== m_ovf) begin errors++; $display("FAIL rand_overflow it%0d got=%b exp=%b", it, o_ovf, m_ovf); end
                end
            end else if (r == 6) begin
                sel = 1'($urandom_range(0, 1));
            end else begin
                press(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 7) == 0));
                checks++; if (o_led !== m_led) begin errors++; $display("FAIL rand_press_led it%0d got=%h exp=%h", it, o_led, m_led); end
                checks++; if (o_run !== (m_st == MR || m_st == ML)) begin errors++; $display("FAIL rand_press_running it%0d got=%b", it, o_run); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_count();
        test_lap();
        test_overflow();
        test_simultaneous();
        test_prescaler();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
